// File: rtl/fifo_rx_credit.sv
// SpaceWire receive FIFO with integrated FCT credit engine and sticky credit-error flag.
// Optional: define FIFO_RX_CREDIT_ERR_FLUSH_EN to flush the FIFO on a credit violation.
module fifo_rx_credit #(
  parameter int DWIDTH       = 9,
  parameter int AWIDTH       = 6,
  parameter int CREDIT_CHUNK = 8,
  parameter int MAX_CREDIT   = 56,
  parameter int CWIDTH       = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] data_out,
  output logic              rd_valid,
  output logic              fct_req,
  input  logic              fct_ack,
  output logic              f_full,
  output logic              f_empty,
  output logic [AWIDTH:0]   counter,
  output logic [CWIDTH-1:0] credit,
  output logic              overflow_credit_error
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0]   CNT_ONE  = 1;
  localparam logic [AWIDTH-1:0] PTR_ONE  = 1;
  localparam logic [CWIDTH-1:0] CRD_ONE  = 1;
  localparam logic [CWIDTH-1:0] CRD_CHNK = CWIDTH'(CREDIT_CHUNK);
  localparam logic [AWIDTH:0]   CNT_FULL = (AWIDTH+1)'(DEPTH);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AWIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [AWIDTH:0]   r_cnt;
  logic [CWIDTH-1:0] r_credit;
  logic [DWIDTH-1:0] r_data_out;
  logic              r_rd_valid, r_fct_req, r_err, r_full, r_empty;
  logic              r_wr_q, r_rd_q;

  logic              w_wr_acc, w_rd_acc, w_cerr, w_grant, w_flush;
  logic              w_wr_do, w_rd_do, w_err_nxt, w_req_nxt;
  logic [AWIDTH:0]   w_cnt_nxt;
  logic [CWIDTH-1:0] w_cred_nxt;
  int                w_room, w_cap;

  always_comb begin
    w_wr_acc = wr_en & ~r_wr_q;
    w_rd_acc = rd_en & ~r_rd_q & ~r_empty;
    w_cerr   = w_wr_acc & (r_credit == '0);
    w_grant  = fct_ack & r_fct_req;
`ifdef FIFO_RX_CREDIT_ERR_FLUSH_EN
    w_flush  = w_cerr;
`else
    w_flush  = 1'b0;
`endif
    w_wr_do  = w_wr_acc & ~r_full & ~w_flush;
    w_rd_do  = w_rd_acc & ~w_flush;

    w_cnt_nxt = r_cnt;
    if (w_flush)
      w_cnt_nxt = '0;
    else if (w_wr_do && !w_rd_do)
      w_cnt_nxt = r_cnt + CNT_ONE;
    else if (!w_wr_do && w_rd_do)
      w_cnt_nxt = r_cnt - CNT_ONE;

    // Credit is consumed by every accepted write that had credit, even one dropped on full.
    w_cred_nxt = r_credit;
    if (w_flush)
      w_cred_nxt = '0;
    else begin
      if (w_grant)
        w_cred_nxt = w_cred_nxt + CRD_CHNK;
      if (w_wr_acc && !w_cerr)
        w_cred_nxt = w_cred_nxt - CRD_ONE;
    end

    w_err_nxt = r_err | w_cerr;
    w_room    = DEPTH - int'(w_cnt_nxt) - int'(w_cred_nxt);
    w_cap     = int'(w_cred_nxt) + CREDIT_CHUNK;
    w_req_nxt = (w_room >= CREDIT_CHUNK) && (w_cap <= MAX_CREDIT);
`ifdef FIFO_RX_CREDIT_ERR_FLUSH_EN
    if (w_err_nxt)
      w_req_nxt = 1'b0;
`endif
  end

  // Storage is left unreset; the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (w_wr_do)
      r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_credit   <= '0;
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
      r_fct_req  <= 1'b0;
      r_err      <= 1'b0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_wr_q     <= 1'b0;
      r_rd_q     <= 1'b0;
    end else begin
      r_wr_q     <= wr_en;
      r_rd_q     <= rd_en;
      r_rd_valid <= w_rd_do;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_do)
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_rd_do) begin
          r_rd_ptr   <= r_rd_ptr + PTR_ONE;
          r_data_out <= r_mem[r_rd_ptr];
        end
      end
      r_cnt     <= w_cnt_nxt;
      r_credit  <= w_cred_nxt;
      r_err     <= w_err_nxt;
      r_fct_req <= w_req_nxt;
      r_full    <= (w_cnt_nxt == CNT_FULL);
      r_empty   <= (w_cnt_nxt == '0);
    end
  end

  assign data_out              = r_data_out;
  assign rd_valid              = r_rd_valid;
  assign fct_req               = r_fct_req;
  assign f_full                = r_full;
  assign f_empty               = r_empty;
  assign counter               = r_cnt;
  assign credit                = r_credit;
  assign overflow_credit_error = r_err;

endmodule

// File: tb/tb_fifo_rx_credit.sv
// Directed self-checking bench for fifo_rx_credit (default parameters).
// Expectations follow FIFO_RX_CREDIT_ERR_FLUSH_EN when that macro is defined.
module tb_fifo_rx_credit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [8:0] data_in = '0;
  logic       rd_en = 1'b0;
  logic [8:0] data_out;
  logic       rd_valid;
  logic       fct_req;
  logic       fct_ack = 1'b0;
  logic       f_full, f_empty;
  logic [6:0] counter;
  logic [5:0] credit;
  logic       overflow_credit_error;

  int checks = 0;
  int errors = 0;

  fifo_rx_credit #(.DWIDTH(9), .AWIDTH(6), .CREDIT_CHUNK(8), .MAX_CREDIT(56), .CWIDTH(6)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .rd_valid(rd_valid), .fct_req(fct_req), .fct_ack(fct_ack),
    .f_full(f_full), .f_empty(f_empty), .counter(counter), .credit(credit),
    .overflow_credit_error(overflow_credit_error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_pulse(input logic [8:0] d);
    data_in = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
  endtask

  task automatic rd_pulse_chk(input string tag, input logic [8:0] d);
    rd_en = 1'b1;
    tick();
    chk({tag, "_vld"}, 32'(rd_valid), 1);
    chk({tag, "_dat"}, 32'(data_out), 32'(d));
    rd_en = 1'b0;
    tick();
    chk({tag, "_vld0"}, 32'(rd_valid), 0);
  endtask

  task automatic ack_n(input int n);
    fct_ack = 1'b1;
    repeat (n) tick();
    fct_ack = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cnt"},   32'(counter), 0);
    chk({tag, "_crd"},   32'(credit), 0);
    chk({tag, "_emp"},   32'(f_empty), 1);
    chk({tag, "_full"},  32'(f_full), 0);
    chk({tag, "_req"},   32'(fct_req), 0);
    chk({tag, "_vld"},   32'(rd_valid), 0);
    chk({tag, "_dout"},  32'(data_out), 0);
    chk({tag, "_err"},   32'(overflow_credit_error), 0);
  endtask

  function automatic logic [8:0] pat(input int i);
    pat = 9'((i * 37 + 5) % 512);
  endfunction

  initial begin
    // Reset state, then credit grant up to MAX_CREDIT
    tick(); tick();
    chk_reset_state("rst");
    reset = 1'b0;
    tick();
    chk("req_after_rst", 32'(fct_req), 1);
    ack_n(7);
    chk("grant_crd", 32'(credit), 56);
    chk("grant_req", 32'(fct_req), 0);
    chk("grant_emp", 32'(f_empty), 1);
    chk("grant_cnt", 32'(counter), 0);
    ack_n(1);
    chk("stray_ack", 32'(credit), 56);

    // Eight writes consume credit and re-arm fct_req
    for (int i = 1; i <= 8; i++) wr_pulse(9'(i));
    chk("w8_cnt", 32'(counter), 8);
    chk("w8_crd", 32'(credit), 48);
    chk("w8_req", 32'(fct_req), 1);
    ack_n(1);
    chk("w8_ack_crd", 32'(credit), 56);
    chk("w8_ack_req", 32'(fct_req), 0);

    // Level-held wr_en is a single write
    data_in = 9'h009;
    wr_en = 1'b1;
    repeat (5) tick();
    wr_en = 1'b0;
    tick();
    chk("hold_cnt", 32'(counter), 9);
    chk("hold_crd", 32'(credit), 55);

    rd_pulse_chk("rd1", 9'h001);
    rd_pulse_chk("rd2", 9'h002);
    chk("rd_cnt", 32'(counter), 7);

    // Simultaneous write and read at counter=10
    wr_pulse(9'h00A); wr_pulse(9'h00B); wr_pulse(9'h00C);
    chk("pre_sim_cnt", 32'(counter), 10);
    data_in = 9'h00D;
    wr_en = 1'b1;
    rd_en = 1'b1;
    tick();
    chk("sim_cnt", 32'(counter), 10);
    chk("sim_crd", 32'(credit), 51);
    chk("sim_dat", 32'(data_out), 3);
    chk("sim_vld", 32'(rd_valid), 1);
    wr_en = 1'b0;
    rd_en = 1'b0;
    tick();

    // Write with zero credit
    reset = 1'b1; tick(); reset = 1'b0; tick();
    wr_pulse(9'h1FF);
    chk("cerr_flag", 32'(overflow_credit_error), 1);
`ifdef FIFO_RX_CREDIT_ERR_FLUSH_EN
    chk("cerr_cnt", 32'(counter), 0);
    chk("cerr_emp", 32'(f_empty), 1);
    chk("cerr_req", 32'(fct_req), 0);
`else
    chk("cerr_cnt", 32'(counter), 1);
    chk("cerr_req", 32'(fct_req), 1);
`endif
    repeat (3) tick();
    chk("cerr_sticky", 32'(overflow_credit_error), 1);

    // Offset the pointers, then fill 64 entries so the drain crosses the wrap
    reset = 1'b1; tick(); reset = 1'b0; tick();
    ack_n(7);
    for (int i = 0; i < 8; i++) wr_pulse(9'h100 + 9'(i));
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; tick(); rd_en = 1'b0; tick();
    end
    chk("off_emp", 32'(f_empty), 1);
    chk("off_req", 32'(fct_req), 1);
    ack_n(1);
    chk("off_crd", 32'(credit), 56);
    for (int i = 0; i < 56; i++) wr_pulse(pat(i));
    chk("f56_req", 32'(fct_req), 1);
    ack_n(1);
    for (int i = 56; i < 64; i++) wr_pulse(pat(i));
    chk("full_flag", 32'(f_full), 1);
    chk("full_cnt", 32'(counter), 64);
    chk("full_crd", 32'(credit), 0);
    chk("full_req", 32'(fct_req), 0);
    chk("full_err", 32'(overflow_credit_error), 0);
`ifndef FIFO_RX_CREDIT_ERR_FLUSH_EN
    wr_pulse(9'h0AA);
    chk("drop_cnt", 32'(counter), 64);
    chk("drop_full", 32'(f_full), 1);
`endif
    for (int i = 0; i < 64; i++) rd_pulse_chk($sformatf("drain%0d", i), pat(i));
    chk("drain_emp", 32'(f_empty), 1);
    chk("drain_cnt", 32'(counter), 0);
    chk("drain_full", 32'(f_full), 0);

    // Read while empty is ignored
    rd_en = 1'b1; tick();
    chk("empty_rd_vld", 32'(rd_valid), 0);
    chk("empty_rd_dat", 32'(data_out), 32'(pat(63)));
    rd_en = 1'b0; tick();

    // Reset in the middle of a drain
    ack_n(1);
    for (int i = 0; i < 4; i++) wr_pulse(9'h050 + 9'(i));
    rd_pulse_chk("pre_rst_rd", 9'h050);
    rd_en = 1'b1;
    reset = 1'b1;
    tick();
    chk_reset_state("midrst");
    reset = 1'b0;
    rd_en = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
